// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD op sequencer and the ALU slices it drives.
package simd_pkg;

    localparam int unsigned W_DEFAULT = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/simd_op_sequencer.sv
// Time-multiplexes one LANES-wide vector op over an external array of ALUS
// combinational ALU slices, ALUS lanes per cycle, then holds the result for writeback.
module simd_op_sequencer
    import simd_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned ALUS  = 2,
    parameter int unsigned W     = W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [LANES*W-1:0]    in_a,
    input  logic [LANES*W-1:0]    in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*W-1:0]    out_c,
    output logic [2:0]            alu_ctrl,
    output logic [ALUS*W-1:0]     alu_a,
    output logic [ALUS*W-1:0]     alu_b,
    input  logic [ALUS*W-1:0]     alu_c,
    output logic                  busy
);

    localparam int unsigned PASSES = LANES / ((ALUS == 0) ? 1 : ALUS);
    localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned VW     = LANES * W;
    localparam int unsigned SW     = ALUS * W;

    if (ALUS == 0 || ALUS > LANES || (LANES % ALUS) != 0) begin : g_bad_params
        $error("simd_op_sequencer: LANES (%0d) must be a non-zero multiple of ALUS (%0d)", LANES, ALUS);
    end

    state_t          state;
    logic [PW-1:0]   pass;
    logic [2:0]      op_r;
    logic [VW-1:0]   a_r;
    logic [VW-1:0]   b_r;
    logic [VW-1:0]   res_r;

    logic            accept;
    logic            last_pass;
    logic [31:0]     sh;
    logic [VW-1:0]   a_sh;
    logic [VW-1:0]   b_sh;
    logic [VW-1:0]   res_nx;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_pass = (pass == PW'(PASSES - 1));
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_c     = res_r;

    // Lane window selection by shifting the whole vector avoids variable part-selects.
    always_comb begin
        sh     = 32'(pass) * SW;
        a_sh   = a_r >> sh;
        b_sh   = b_r >> sh;
        res_nx = (res_r & ~(VW'({SW{1'b1}}) << sh)) | (VW'(alu_c) << sh);
    end

    always_comb begin
        alu_ctrl = '0;
        alu_a    = '0;
        alu_b    = '0;
        if (state == RUN) begin
            alu_ctrl = op_r;
            alu_a    = a_sh[SW-1:0];
            alu_b    = b_sh[SW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pass  <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_r  <= in_op;
                        a_r   <= in_a;
                        b_r   <= in_b;
                        pass  <= '0;
                        state <= RUN;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_r <= res_nx;
                    if (last_pass) begin
                        state <= DONE;
                    end else begin
                        pass <= pass + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_op_sequencer.sv
// Scoreboard bench for simd_op_sequencer: a 2-slice and an 8-slice instance, each with a behavioural ALU array.
module tb_simd_op_sequencer;
    import simd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8 lanes over 2 slices
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  in_op, alu_ctrl;
    logic [63:0] in_a, in_b, out_c;
    logic [15:0] alu_a, alu_b, alu_c;

    // 8 lanes over 8 slices
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [2:0]  in_op8, alu_ctrl8;
    logic [63:0] in_a8, in_b8, out_c8, alu_a8, alu_b8, alu_c8;

    logic [63:0] sb[$];
    logic [63:0] sb8[$];
    int n_cmp = 0;
    int n_bad = 0;

    simd_op_sequencer #(.LANES(8), .ALUS(2), .W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .busy(busy)
    );

    simd_op_sequencer #(.LANES(8), .ALUS(8), .W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
        .in_a(in_a8), .in_b(in_b8), .out_valid(out_valid8), .out_ready(out_ready8), .out_c(out_c8),
        .alu_ctrl(alu_ctrl8), .alu_a(alu_a8), .alu_b(alu_b8), .alu_c(alu_c8), .busy(busy8)
    );

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_MUL: return p[7:0];
            OP_OR:  return a | b;
            OP_AND: return a & b;
            OP_XOR: return a ^ b;
            OP_SHL: return a << b;
            default: return a >> b;
        endcase
    endfunction

    always_comb begin
        alu_c = '0;
        for (int k = 0; k < 2; k++) alu_c[k*8 +: 8] = alu(alu_ctrl, alu_a[k*8 +: 8], alu_b[k*8 +: 8]);
    end

    always_comb begin
        alu_c8 = '0;
        for (int k = 0; k < 8; k++) alu_c8[k*8 +: 8] = alu(alu_ctrl8, alu_a8[k*8 +: 8], alu_b8[k*8 +: 8]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            else chk("out_c", out_c, sb.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (sb8.size() == 0) chk("unexpected_out_valid8", 64'(out_valid8), 64'd0);
            else chk("out_c8", out_c8, sb8.pop_front());
        end
    end

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        bit ok;
        ok = 1'b0;
        sb.push_back(exp);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && sb8.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_op8 = '0; in_a8 = '0; in_b8 = '0; out_ready8 = 1'b1;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_out_c", out_c, 64'd0);
        chk("rst_out_valid8", 64'(out_valid8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 2: add, four RUN cycles then out_valid
        issue(OP_ADD, 64'h1010101010101010, 64'h0101010101010101, 64'h1111111111111111);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            chk("add_run_busy", 64'(busy), 64'd1);
            chk("add_run_out_valid", 64'(out_valid), 64'd0);
            chk("add_run_alu_ctrl", 64'(alu_ctrl), 64'd0);
            chk("add_run_alu_a", 64'(alu_a), 64'h1010);
        end
        @(negedge clk);
        chk("add_out_valid_lat5", 64'(out_valid), 64'd1);
        drain();
        @(negedge clk);
        chk("idle_alu_a", 64'(alu_a), 64'd0);
        @(posedge clk); #1;

        // 3: wraparound add, truncating mul, per-lane shl
        issue(OP_ADD, 64'hFFFFFFFFFFFFFFFF, 64'h0202020202020202, 64'h0101010101010101);
        drain();
        issue(OP_MUL, 64'h1010101010101010, 64'h1010101010101010, 64'h0000000000000000);
        drain();
        issue(OP_SHL, 64'h0101010101010101, 64'h0706050403020100, 64'h8040201008040201);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            chk("shl_alu_ctrl", 64'(alu_ctrl), 64'(OP_SHL));
            chk("shl_alu_b", 64'(alu_b), 64'({8'(2*p+1), 8'(2*p)}));
        end
        drain();

        // 4: backpressure in DONE, then back-to-back accept
        out_ready = 1'b0;
        issue(OP_OR, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 64'hFFFFFFFFFFFFFFFF);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) chk("bp_valid_timeout", 64'd0, 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_c_stable", out_c, 64'hFFFFFFFFFFFFFFFF);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(OP_SHR, 64'h8080808080808080, 64'h0707070707070707, 64'h0101010101010101);
        @(negedge clk);
        chk("b2b_run_busy", 64'(busy), 64'd1);
        chk("b2b_run_out_valid", 64'(out_valid), 64'd0);
        chk("b2b_run_alu_ctrl", 64'(alu_ctrl), 64'(OP_SHR));
        drain();

        // 5: reset during pass 2 aborts the op
        issue(OP_SUB, 64'h3030303030303030, 64'h1010101010101010, 64'h2020202020202020);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_out_valid", 64'(out_valid), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
        end
        @(posedge clk); #1;
        issue(OP_AND, 64'hF0F0F0F0F0F0F0F0, 64'h3C3C3C3C3C3C3C3C, 64'h3030303030303030);
        drain();

        // 6: one slice per lane, single RUN cycle
        sb8.push_back(64'h5555555555555555);
        in_valid8 = 1'b1; in_op8 = OP_XOR; in_a8 = 64'hAAAAAAAAAAAAAAAA; in_b8 = 64'hFFFFFFFFFFFFFFFF;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready8) ok = 1'b1;
        end
        if (!ok) chk("accept8_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0; in_op8 = '0; in_a8 = '0; in_b8 = '0;
        @(negedge clk);
        chk("x8_run_busy", 64'(busy8), 64'd1);
        chk("x8_run_out_valid", 64'(out_valid8), 64'd0);
        chk("x8_alu_ctrl", 64'(alu_ctrl8), 64'(OP_XOR));
        chk("x8_alu_a", alu_a8, 64'hAAAAAAAAAAAAAAAA);
        @(negedge clk);
        chk("x8_out_valid_lat2", 64'(out_valid8), 64'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
